// File: rtl/sc_level_pkg.sv
// Shared definitions for the Frogger level sequencer and the blocks that consume its outputs.
// State encodings are fixed so the score and display logic can decode them directly.
package sc_level_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE       = 3'd0,
        PLAYING    = 3'd1,
        LEVEL_DONE = 3'd2,
        WON        = 3'd3,
        LOST       = 3'd4
    } state_e;

    localparam int DEFAULT_NUM_LEVELS      = 3;
    localparam int DEFAULT_PROGRESS_TARGET = 12;
    localparam int DEFAULT_LIVES           = 3;

endpackage

// File: rtl/sc_level_pause_counter.sv
// Loadable down-counter timing the pause between levels; it stops at zero and flags it.
module sc_level_pause_counter #(
    parameter int               WIDTH      = 26,
    parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VALUE;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sc_level_sequencer.sv
// Frogger level sequencer: level/lives tracking and play, pause and end-of-game phases.
// Every output is a register loaded from the next-state logic, so it changes one edge after its cause.
module sc_level_sequencer
    import sc_level_pkg::*;
#(
    parameter int NUM_LEVELS        = DEFAULT_NUM_LEVELS,
    parameter int LEVEL_WIDTH       = 3,
    parameter int PROGRESS_WIDTH    = 5,
    parameter int PROGRESS_TARGET   = DEFAULT_PROGRESS_TARGET,
    parameter int LIVES             = DEFAULT_LIVES,
    parameter int LIVES_WIDTH       = 2,
    parameter int INTERLEVEL_CYCLES = 50000000
) (
    input  logic                      SC_LEVEL_SEQUENCER_CLOCK_50,
    input  logic                      SC_LEVEL_SEQUENCER_RESET_InHigh,
    input  logic                      SC_LEVEL_SEQUENCER_Start_In,
    input  logic                      SC_LEVEL_SEQUENCER_Death_In,
    input  logic [PROGRESS_WIDTH-1:0] SC_LEVEL_SEQUENCER_ProgressCount_In,
    output logic [LEVEL_WIDTH-1:0]    SC_LEVEL_SEQUENCER_Level_Out,
    output logic [LIVES_WIDTH-1:0]    SC_LEVEL_SEQUENCER_Lives_Out,
    output logic                      SC_LEVEL_SEQUENCER_StartCount_Out,
    output logic                      SC_LEVEL_SEQUENCER_LevelFinished_Out,
    output logic                      SC_LEVEL_SEQUENCER_Playing_Out,
    output logic                      SC_LEVEL_SEQUENCER_FinishedGame_Out,
    output logic                      SC_LEVEL_SEQUENCER_GameOver_Out
);

    localparam int                        PAUSE_W    = (INTERLEVEL_CYCLES > 1) ? $clog2(INTERLEVEL_CYCLES) : 1;
    localparam logic [PAUSE_W-1:0]        PAUSE_LOAD = PAUSE_W'(INTERLEVEL_CYCLES - 1);
    localparam logic [PROGRESS_WIDTH-1:0] TARGET     = PROGRESS_WIDTH'(PROGRESS_TARGET);
    localparam logic [LEVEL_WIDTH-1:0]    LAST_LEVEL = LEVEL_WIDTH'(NUM_LEVELS);
    localparam logic [LIVES_WIDTH-1:0]    FULL_LIVES = LIVES_WIDTH'(LIVES);

    state_e                   state_q, state_d;
    logic [LEVEL_WIDTH-1:0]   level_q, level_d;
    logic [LIVES_WIDTH-1:0]   lives_q, lives_d;
    logic                     start_count_q, start_count_d;
    logic                     level_fin_q, level_fin_d;
    logic                     playing_q, playing_d;
    logic                     finished_q, finished_d;
    logic                     game_over_q, game_over_d;
    logic                     respawn;
    logic                     pause_load, pause_en, pause_zero;

    sc_level_pause_counter #(
        .WIDTH      (PAUSE_W),
        .LOAD_VALUE (PAUSE_LOAD)
    ) u_pause (
        .clk_i  (SC_LEVEL_SEQUENCER_CLOCK_50),
        .rst_i  (SC_LEVEL_SEQUENCER_RESET_InHigh),
        .load_i (pause_load),
        .en_i   (pause_en),
        .zero_o (pause_zero)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        lives_d     = lives_q;
        level_fin_d = 1'b0;
        respawn     = 1'b0;
        pause_load  = 1'b0;
        pause_en    = 1'b0;
        case (state_q)
            IDLE, WON, LOST: begin
                if (SC_LEVEL_SEQUENCER_Start_In) begin
                    state_d = PLAYING;
                    level_d = LEVEL_WIDTH'(1);
                    lives_d = FULL_LIVES;
                end
            end
            PLAYING: begin
                // Reaching the target takes priority over a death in the same cycle.
                if (SC_LEVEL_SEQUENCER_ProgressCount_In >= TARGET) begin
                    state_d     = LEVEL_DONE;
                    level_fin_d = 1'b1;
                    pause_load  = 1'b1;
                end else if (SC_LEVEL_SEQUENCER_Death_In) begin
                    if (lives_q > LIVES_WIDTH'(1)) begin
                        lives_d = lives_q - LIVES_WIDTH'(1);
                        respawn = 1'b1;
                    end else begin
                        lives_d = '0;
                        state_d = LOST;
                    end
                end
            end
            LEVEL_DONE: begin
                if (!pause_zero) begin
                    pause_en = 1'b1;
                end else if (level_q >= LAST_LEVEL) begin
                    state_d = WON;
                    level_d = LAST_LEVEL;
                end else begin
                    state_d = PLAYING;
                    level_d = level_q + LEVEL_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
                lives_d = FULL_LIVES;
            end
        endcase
        // The progress counter is held clear whenever the frog is not actively playing.
        start_count_d = (state_d != PLAYING) || respawn;
        playing_d     = (state_d == PLAYING);
        finished_d    = (state_d == WON);
        game_over_d   = (state_d == LOST);
    end

    always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50) begin
        if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
            state_q       <= IDLE;
            level_q       <= '0;
            lives_q       <= FULL_LIVES;
            start_count_q <= 1'b1;
            level_fin_q   <= 1'b0;
            playing_q     <= 1'b0;
            finished_q    <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            start_count_q <= start_count_d;
            level_fin_q   <= level_fin_d;
            playing_q     <= playing_d;
            finished_q    <= finished_d;
            game_over_q   <= game_over_d;
        end
    end

    assign SC_LEVEL_SEQUENCER_Level_Out         = level_q;
    assign SC_LEVEL_SEQUENCER_Lives_Out         = lives_q;
    assign SC_LEVEL_SEQUENCER_StartCount_Out    = start_count_q;
    assign SC_LEVEL_SEQUENCER_LevelFinished_Out = level_fin_q;
    assign SC_LEVEL_SEQUENCER_Playing_Out       = playing_q;
    assign SC_LEVEL_SEQUENCER_FinishedGame_Out  = finished_q;
    assign SC_LEVEL_SEQUENCER_GameOver_Out      = game_over_q;

endmodule
